// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU pipeline.
// The IF/ID register layout and its bubble encoding live here so that
// fetch and decode agree on them.
package cpu_pkg;

  // sll $0,$0,0: architecturally a no-op
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Default PC loaded on reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } ifid_t;

  // Empty pipeline slot: not valid, NOP instruction, zeroed PC fields
  localparam ifid_t BUBBLE = '{valid: 1'b0, pc: 32'h0, pc_plus4: 32'h0, instr: NOP_INSTR};

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register.
// Flush takes priority over load; with neither asserted the contents hold.
// Reset is asynchronous and returns the register to a bubble.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  ifid_t q_reg;

  // Register update: reset/flush to bubble, otherwise load or hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= BUBBLE;
    end else if (flush) begin
      q_reg <= BUBBLE;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage.
// Owns the PC, presents it to the combinational instruction memory and
// captures the returned word into the IF/ID register. Redirect beats
// flush beats stall. A sticky flag records misaligned redirect targets,
// and two wrapping counters track accepted fetches and stalled cycles.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  output logic [31:0]      pc_o,
  output logic             ifid_valid_o,
  output logic [31:0]      ifid_pc_o,
  output logic [31:0]      ifid_pc_plus4_o,
  output logic [31:0]      ifid_instr_o,
  output logic             misaligned_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      pc_reg;
  logic [31:0]      pc_next;
  logic [31:0]      pc_plus4;
  logic             misaligned_reg;
  logic [CNT_W-1:0] fetch_cnt_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic  ifid_load;
  logic  ifid_flush;
  logic  fetch_accept;
  logic  stall_count;
  ifid_t ifid_d;
  ifid_t ifid_q;

  // Wraps modulo 2^32, so 0xFFFFFFFC advances to 0
  assign pc_plus4 = pc_reg + 32'd4;

  // Redirect and flush both squash the slot; stall only blocks a fresh load
  assign ifid_flush   = redirect_i | flush_i;
  assign ifid_load    = ~stall_i;
  assign fetch_accept = ~redirect_i & ~flush_i & ~stall_i;
  assign stall_count  = stall_i & ~redirect_i;

  assign ifid_d = '{valid: 1'b1, pc: pc_reg, pc_plus4: pc_plus4, instr: imem_rdata};

  // Next-PC selection: word-aligned redirect target, hold on stall, else sequential
  always_comb begin
    pc_next = pc_plus4;
    if (redirect_i) begin
      pc_next = {redirect_pc_i[31:2], 2'b00};
    end else if (stall_i) begin
      pc_next = pc_reg;
    end
  end

  // PC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  // Sticky misaligned-target flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned_reg <= 1'b0;
    end else if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
      misaligned_reg <= 1'b1;
    end
  end

  // Debug counters for accepted fetches and stalled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (fetch_accept) begin
        fetch_cnt_reg <= fetch_cnt_reg + CNT_ONE;
      end
      if (stall_count) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      end
    end
  end

  ifid_reg u_ifid_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (ifid_load),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign imem_addr       = pc_reg;
  assign pc_o            = pc_reg;
  assign ifid_valid_o    = ifid_q.valid;
  assign ifid_pc_o       = ifid_q.pc;
  assign ifid_pc_plus4_o = ifid_q.pc_plus4;
  assign ifid_instr_o    = ifid_q.instr;
  assign misaligned_o    = misaligned_reg;
  assign fetch_cnt_o     = fetch_cnt_reg;
  assign stall_cnt_o     = stall_cnt_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage.
// Instruction memory is a combinational model: address 0 returns
// 32'h34100006, any other address A returns 32'h20000000 | A.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o;
  logic        ifid_valid_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc_plus4_o;
  logic [31:0] ifid_instr_o;
  logic        misaligned_o;
  logic [31:0] fetch_cnt_o;
  logic [31:0] stall_cnt_o;

  int checks;
  int errors;

  fetch_stage #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .pc_o            (pc_o),
    .ifid_valid_o    (ifid_valid_o),
    .ifid_pc_o       (ifid_pc_o),
    .ifid_pc_plus4_o (ifid_pc_plus4_o),
    .ifid_instr_o    (ifid_instr_o),
    .misaligned_o    (misaligned_o),
    .fetch_cnt_o     (fetch_cnt_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory model
  always_comb begin
    imem_rdata = 32'h2000_0000 | imem_addr;
    if (imem_addr == 32'h0) imem_rdata = 32'h3410_0006;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    stall_i = 1'b0;
    flush_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;

    // Reset state
    #2;
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, ifid_valid_o}, 32'h0);
    chk("rst_instr", ifid_instr_o, 32'h0);
    chk("rst_misaligned", {31'h0, misaligned_o}, 32'h0);
    chk("rst_fetch_cnt", fetch_cnt_o, 32'h0);
    chk("rst_stall_cnt", stall_cnt_o, 32'h0);
    step();
    step();
    chk("rst_held_pc", pc_o, 32'h0);
    $display("txn reset: pc=%h valid=%b", pc_o, ifid_valid_o);

    // Release reset between edges, first fetch
    #3;
    rst = 1'b0;
    step();
    chk("first_instr", ifid_instr_o, 32'h3410_0006);
    chk("first_ifid_pc", ifid_pc_o, 32'h0);
    chk("first_pc_plus4", ifid_pc_plus4_o, 32'h4);
    chk("first_pc", pc_o, 32'h4);
    chk("first_fetch_cnt", fetch_cnt_o, 32'h1);
    chk("first_valid", {31'h0, ifid_valid_o}, 32'h1);
    $display("txn fetch: ifid_pc=%h instr=%h pc=%h", ifid_pc_o, ifid_instr_o, pc_o);

    step();
    chk("seq_pc", pc_o, 32'h8);
    chk("seq_ifid_pc", ifid_pc_o, 32'h4);
    chk("seq_instr", ifid_instr_o, 32'h2000_0004);
    $display("txn fetch: ifid_pc=%h instr=%h pc=%h", ifid_pc_o, ifid_instr_o, pc_o);

    // Stall for two edges
    stall_i = 1'b1;
    step();
    step();
    chk("stall_pc", pc_o, 32'h8);
    chk("stall_ifid_pc", ifid_pc_o, 32'h4);
    chk("stall_instr", ifid_instr_o, 32'h2000_0004);
    chk("stall_valid", {31'h0, ifid_valid_o}, 32'h1);
    chk("stall_cnt2", stall_cnt_o, 32'h2);
    chk("stall_fetch_cnt", fetch_cnt_o, 32'h2);
    $display("txn stall x2: pc=%h stall_cnt=%0d", pc_o, stall_cnt_o);

    stall_i = 1'b0;
    step();
    chk("unstall_ifid_pc", ifid_pc_o, 32'h8);
    chk("unstall_pc", pc_o, 32'hC);
    chk("unstall_fetch_cnt", fetch_cnt_o, 32'h3);
    $display("txn unstall: ifid_pc=%h pc=%h", ifid_pc_o, pc_o);

    // Redirect to 0x14
    redirect_i = 1'b1;
    redirect_pc_i = 32'h14;
    step();
    redirect_i = 1'b0;
    chk("redir_pc", pc_o, 32'h14);
    chk("redir_valid", {31'h0, ifid_valid_o}, 32'h0);
    chk("redir_instr", ifid_instr_o, 32'h0);
    chk("redir_bubble_pc", ifid_pc_o, 32'h0);
    chk("redir_bubble_pc4", ifid_pc_plus4_o, 32'h0);
    chk("redir_fetch_cnt", fetch_cnt_o, 32'h3);
    $display("txn redirect 0x14: pc=%h valid=%b", pc_o, ifid_valid_o);

    step();
    chk("redir_next_ifid_pc", ifid_pc_o, 32'h14);
    chk("redir_next_instr", ifid_instr_o, 32'h2000_0014);
    chk("redir_next_pc", pc_o, 32'h18);
    $display("txn fetch target: ifid_pc=%h instr=%h", ifid_pc_o, ifid_instr_o);

    // Redirect + stall + flush together
    redirect_i = 1'b1;
    stall_i = 1'b1;
    flush_i = 1'b1;
    redirect_pc_i = 32'h40;
    step();
    redirect_i = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    chk("all3_pc", pc_o, 32'h40);
    chk("all3_valid", {31'h0, ifid_valid_o}, 32'h0);
    chk("all3_instr", ifid_instr_o, 32'h0);
    chk("all3_stall_cnt", stall_cnt_o, 32'h2);
    $display("txn redirect+stall+flush: pc=%h stall_cnt=%0d", pc_o, stall_cnt_o);

    // Move to 0x20, then flush with stall
    redirect_i = 1'b1;
    redirect_pc_i = 32'h20;
    step();
    redirect_i = 1'b0;
    chk("goto20_pc", pc_o, 32'h20);
    flush_i = 1'b1;
    stall_i = 1'b1;
    step();
    flush_i = 1'b0;
    stall_i = 1'b0;
    chk("flushstall_pc", pc_o, 32'h20);
    chk("flushstall_valid", {31'h0, ifid_valid_o}, 32'h0);
    chk("flushstall_stall_cnt", stall_cnt_o, 32'h3);
    $display("txn flush+stall: pc=%h stall_cnt=%0d", pc_o, stall_cnt_o);

    // Flush alone: PC advances, slot squashed, no fetch counted
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_pc", pc_o, 32'h24);
    chk("flush_valid", {31'h0, ifid_valid_o}, 32'h0);
    chk("flush_fetch_cnt", fetch_cnt_o, 32'h4);
    $display("txn flush: pc=%h valid=%b", pc_o, ifid_valid_o);

    step();
    chk("post_flush_ifid_pc", ifid_pc_o, 32'h24);
    chk("post_flush_fetch_cnt", fetch_cnt_o, 32'h5);
    $display("txn fetch: ifid_pc=%h pc=%h", ifid_pc_o, pc_o);

    // Misaligned redirect target
    chk("pre_misaligned", {31'h0, misaligned_o}, 32'h0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h16;
    step();
    redirect_i = 1'b0;
    chk("misal_pc", pc_o, 32'h14);
    chk("misal_flag", {31'h0, misaligned_o}, 32'h1);
    $display("txn redirect 0x16: pc=%h misaligned=%b", pc_o, misaligned_o);
    for (int i = 0; i < 10; i++) step();
    chk("misal_sticky", {31'h0, misaligned_o}, 32'h1);
    chk("misal_run_pc", pc_o, 32'h3C);
    chk("misal_run_fetch_cnt", fetch_cnt_o, 32'd15);
    $display("txn 10 free edges: pc=%h misaligned=%b", pc_o, misaligned_o);

    // PC wrap at top of address space
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    chk("wrap_pc_top", pc_o, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc", pc_o, 32'h0);
    chk("wrap_ifid_pc", ifid_pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", ifid_pc_plus4_o, 32'h0);
    chk("wrap_instr", ifid_instr_o, 32'hFFFF_FFFC);
    $display("txn wrap: pc=%h ifid_pc_plus4=%h", pc_o, ifid_pc_plus4_o);

    // Reach pc=0x30 with a valid IF/ID, then async reset between edges
    redirect_i = 1'b1;
    redirect_pc_i = 32'h2C;
    step();
    redirect_i = 1'b0;
    step();
    chk("pre_arst_pc", pc_o, 32'h30);
    chk("pre_arst_valid", {31'h0, ifid_valid_o}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_imem_addr", imem_addr, 32'h0);
    chk("arst_valid", {31'h0, ifid_valid_o}, 32'h0);
    chk("arst_ifid_pc", ifid_pc_o, 32'h0);
    chk("arst_pc_plus4", ifid_pc_plus4_o, 32'h0);
    chk("arst_instr", ifid_instr_o, 32'h0);
    chk("arst_misaligned", {31'h0, misaligned_o}, 32'h0);
    chk("arst_fetch_cnt", fetch_cnt_o, 32'h0);
    chk("arst_stall_cnt", stall_cnt_o, 32'h0);
    $display("txn async reset: pc=%h valid=%b", pc_o, ifid_valid_o);

    step();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the five-stage pipeline, directly upstream of the combinational instruction memory.
- Holds the PC and drives the fetch address to instruction memory; the instruction word comes back in the same cycle.
- Latches PC, PC+4 and the instruction into the IF/ID pipeline register consumed by decode.
- Honours stall, flush and branch/jump redirect from hazard and branch logic; keeps small fetch/stall counters for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- imem_addr  out  32  fetch address to instruction memory (equals current PC)
- imem_rdata  in  32  instruction word returned combinationally for imem_addr
- stall_i  in  1  hold PC and IF/ID (load-use hazard)
- flush_i  in  1  squash IF/ID contents to a bubble
- redirect_i  in  1  taken branch/jump/jr this cycle
- redirect_pc_i  in  32  target address for redirect
- pc_o  out  32  current PC
- ifid_valid_o  out  1  IF/ID holds a real instruction
- ifid_pc_o  out  32  PC of the IF/ID instruction
- ifid_pc_plus4_o  out  32  PC+4 of the IF/ID instruction (jal link value, branch base)
- ifid_instr_o  out  32  IF/ID instruction word; 32'h0 when bubble
- misaligned_o  out  1  sticky flag: a redirect target had nonzero bits [1:0]
- fetch_cnt_o  out  CNT_W  instructions accepted into IF/ID
- stall_cnt_o  out  CNT_W  cycles spent stalled

Behaviour:
- Reset is rst, asynchronous, active-high. While rst is high: PC=RESET_PC, ifid_valid_o=0, ifid_pc_o=0, ifid_pc_plus4_o=0, ifid_instr_o=0, misaligned_o=0, both counters 0. Asserting rst mid-operation takes effect immediately, without waiting for a clock edge.
- imem_addr = pc_o, combinationally. There are no wait states: imem_rdata is valid in the same cycle.
- Per rising edge, in priority order:
  - redirect_i=1: PC <= {redirect_pc_i[31:2],2'b00}; IF/ID <= bubble. Overrides stall_i and flush_i.
  - flush_i=1: IF/ID <= bubble. PC holds if stall_i=1, otherwise PC <= PC+4.
  - stall_i=1: PC and IF/ID hold; stall_cnt increments.
  - otherwise: IF/ID <= {valid=1, pc=PC, pc_plus4=PC+4, instr=imem_rdata}; PC <= PC+4; fetch_cnt increments.
- Bubble definition: valid=0, instr=32'h0 (sll $0,$0,0), pc and pc_plus4 fields = 0.
- stall_cnt counts only cycles in which stall_i=1 and redirect_i=0. It also counts cycles where flush_i=1 with stall_i=1.
- PC+4 is computed modulo 2^32: 0xFFFFFFFC advances to 0x00000000.
- misaligned_o: set on a redirect edge when redirect_pc_i[1:0]!=0. It stays set until rst.
- Counters wrap modulo 2^CNT_W.
- Latency: an instruction at PC F appears on the ifid_* outputs one edge after PC=F is presented, provided no stall, flush or redirect occurs on that edge.
- Redirect cost: a redirect on edge N fetches the target during cycle N+1. The IF/ID slot after edge N is a bubble. No delay slot is executed.

Decomposition:
- Shared package cpu_pkg:
  - NOP_INSTR = 32'h0
  - RESET_PC default
  - ifid_t struct {valid, pc, pc_plus4, instr}
  - BUBBLE constant of type ifid_t
- Natural sub-module: ifid_reg. It holds the IF/ID pipeline register with load/hold/flush controls and an async reset to BUBBLE.
- PC logic, misaligned flag and counters stay in fetch_stage.

Test Plan:
- Reset and first fetch:
  - While rst=1: imem_addr=0, ifid_valid_o=0, ifid_instr_o=0.
  - Release rst, memory returns 32'h34100006 at addr 0. After 1 edge: ifid_instr_o=32'h34100006, ifid_pc_o=0, ifid_pc_plus4_o=4, pc_o=4, fetch_cnt_o=1.
- Stall:
  - At pc_o=8, hold stall_i=1 for 2 edges: pc_o stays 8, ifid_* unchanged, stall_cnt_o=2.
  - Release stall: ifid_pc_o=8, pc_o=0xC.
- Redirect:
  - At pc_o=0xC, redirect_i=1 with redirect_pc_i=0x14: next cycle pc_o=0x14, ifid_valid_o=0, ifid_instr_o=0.
  - Following edge: ifid_pc_o=0x14.
- Simultaneous events:
  - redirect_i=1, stall_i=1, flush_i=1 together with target 0x40: pc_o=0x40, IF/ID bubble, stall_cnt_o unchanged.
  - flush_i=1 with stall_i=1 at pc_o=0x20: pc_o stays 0x20, IF/ID bubble, stall_cnt_o increments.
- Boundaries:
  - Redirect to 0x16: pc_o=0x14, misaligned_o=1, which stays 1 across 10 further edges until rst.
  - Redirect to 0xFFFFFFFC, then one free edge: pc_o=0, ifid_pc_plus4_o=0.
- Async reset mid-run:
  - Assert rst between edges with pc_o=0x30, ifid_valid_o=1: all outputs return to reset values before the next edge.
